// File: rtl/note_sprite_pkg.sv
// note_sprite_pkg: shared display modes, sprite palette and the
// note-to-mode mapping for note_sprite_engine.
package note_sprite_pkg;

    typedef enum logic [1:0] {
        MODE_STRIPES = 2'd0,
        MODE_SPRITES = 2'd1,
        MODE_RING    = 2'd2,
        MODE_IDLE    = 2'd3
    } mode_t;

    localparam logic [3:0] NO_NOTE = 4'hF;

    localparam logic [11:0] SPRITE_RGB [0:7] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'hF0F, 12'h0FF, 12'hFFF, 12'h888
    };

    function automatic mode_t note_to_mode(input logic [3:0] note);
        return (note > 4'd11) ? MODE_IDLE : mode_t'(2'(note % 4'd3));
    endfunction

endpackage

// File: rtl/note_sprite_engine_stabilizer.sv
// note_stabilizer: a note must persist for stable_ticks prescaler
// ticks before it becomes the committed note.
module note_stabilizer
    import note_sprite_pkg::*;
#(
    parameter int stable_ticks = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       note_vld,
    input  logic [3:0] note_idx,
    output logic [3:0] committed
);

    localparam int WC = (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
    localparam logic [WC-1:0] STABLE = WC'(stable_ticks);

    logic [3:0]    cand_q, cand_d;
    logic [WC-1:0] cnt_q, cnt_d;
    logic [3:0]    committed_q, committed_d;

    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        if (cnt_q == STABLE) begin
            committed_d = cand_q;
        end
        // A fresh note restarts the count even on a tick cycle.
        if (note_vld && note_idx <= 4'd11 && note_idx != cand_q) begin
            cand_d = note_idx;
            cnt_d  = '0;
        end else if (tick && cand_q != NO_NOTE && cnt_q < STABLE) begin
            cnt_d = cnt_q + WC'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q      <= NO_NOTE;
            cnt_q       <= '0;
            committed_q <= NO_NOTE;
        end else begin
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
        end
    end

    assign committed = committed_q;

endmodule

// File: rtl/note_sprite_engine.sv
// note_sprite_engine: note-driven display mode plus n bouncing sprites,
// rendered to a registered RGB pixel with one cycle of latency.
module note_sprite_engine
    import note_sprite_pkg::*;
#(
    parameter int clk_mhz       = 50,
    parameter int w_key         = 4,
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int w_red         = 4,
    parameter int w_green       = 4,
    parameter int w_blue        = 4,
    parameter int n_sprites     = 4,
    parameter int sprite_size   = 32,
    parameter int w_tick        = 20,
    parameter int stable_ticks  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [w_key-1:0]   key,
    input  logic               note_vld,
    input  logic [3:0]         note_idx,
    input  logic [w_x-1:0]     x,
    input  logic [w_y-1:0]     y,
    output logic [w_red-1:0]   red,
    output logic [w_green-1:0] green,
    output logic [w_blue-1:0]  blue,
    output logic [1:0]         mode,
    output logic               tick
);

    localparam int MAX_X = screen_width - sprite_size - 1;
    localparam int MAX_Y = screen_height - sprite_size - 1;
    localparam logic [w_x:0] MAXX_W = MAX_X[w_x:0];
    localparam logic [w_y:0] MAXY_W = MAX_Y[w_y:0];
    localparam int HALF  = sprite_size / 2;
    localparam int R_IN  = HALF * HALF;
    localparam int R_OUT = sprite_size * sprite_size;

    logic [w_tick-1:0]        cnt_q, cnt_d;
    logic [w_x-1:0]           sweep_q, sweep_d;
    logic [3:0]               committed;
    mode_t                    mode_e;
    logic                     move;
    logic [w_x-1:0]           stp_x;
    logic [w_y-1:0]           stp_y;
    logic [n_sprites*w_x-1:0] px_flat;
    logic [n_sprites*w_y-1:0] py_flat;
    logic                     unused_bits;

    assign unused_bits = ^{key[w_key-1:2], 32'(clk_mhz)};

    assign tick    = (cnt_q == '0);
    assign cnt_d   = cnt_q + w_tick'(1);
    assign sweep_d = !tick ? sweep_q :
                     (sweep_q == w_x'(screen_width - 1)) ? '0 :
                     sweep_q + w_x'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            sweep_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sweep_q <= sweep_d;
        end
    end

    note_stabilizer #(
        .stable_ticks(stable_ticks)
    ) u_stab (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .note_vld (note_vld),
        .note_idx (note_idx),
        .committed(committed)
    );

    assign mode_e = note_to_mode(committed);
    assign mode   = mode_e;

    assign move  = tick & ~key[1];
    assign stp_x = key[0] ? w_x'(2) : w_x'(1);
    assign stp_y = key[0] ? w_y'(2) : w_y'(1);

    for (genvar i = 0; i < n_sprites; i++) begin : g_spr
        localparam int PX_RAW = i * screen_width / n_sprites;
        localparam int PX0    = (PX_RAW > MAX_X) ? MAX_X : PX_RAW;

        logic [w_x-1:0] px_q, px_d;
        logic [w_y-1:0] py_q, py_d;
        logic           dx_q, dx_d;
        logic           dy_q, dy_d;

        // Direction bit: 1 = increasing coordinate.
        always_comb begin
            px_d = px_q;
            dx_d = dx_q;
            py_d = py_q;
            dy_d = dy_q;
            if (move) begin
                if (dx_q) begin
                    if ({1'b0, px_q} + {1'b0, stp_x} > MAXX_W) begin
                        px_d = MAXX_W[w_x-1:0];
                        dx_d = 1'b0;
                    end else begin
                        px_d = px_q + stp_x;
                    end
                end else if (px_q < stp_x) begin
                    px_d = '0;
                    dx_d = 1'b1;
                end else begin
                    px_d = px_q - stp_x;
                end
                if (dy_q) begin
                    if ({1'b0, py_q} + {1'b0, stp_y} > MAXY_W) begin
                        py_d = MAXY_W[w_y-1:0];
                        dy_d = 1'b0;
                    end else begin
                        py_d = py_q + stp_y;
                    end
                end else if (py_q < stp_y) begin
                    py_d = '0;
                    dy_d = 1'b1;
                end else begin
                    py_d = py_q - stp_y;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                px_q <= w_x'(PX0);
                py_q <= w_y'(screen_height / 2);
                dx_q <= (i % 2 == 0);
                dy_q <= 1'b1;
            end else begin
                px_q <= px_d;
                py_q <= py_d;
                dx_q <= dx_d;
                dy_q <= dy_d;
            end
        end

        assign px_flat[i*w_x +: w_x] = px_q;
        assign py_flat[i*w_y +: w_y] = py_q;
    end

    int         xi, yi, cx, cy, ddx, ddy, d2;
    logic [11:0] spr_rgb;
    logic        spr_hit;

    assign xi  = int'(x);
    assign yi  = int'(y);
    assign cx  = int'(px_flat[w_x-1:0]) + HALF;
    assign cy  = int'(py_flat[w_y-1:0]) + HALF;
    assign ddx = xi - cx;
    assign ddy = yi - cy;
    assign d2  = ddx * ddx + ddy * ddy;

    // Scan from the highest index so the lowest overlapping sprite wins.
    always_comb begin
        spr_hit = 1'b0;
        spr_rgb = '0;
        for (int i = n_sprites - 1; i >= 0; i--) begin
            if (xi >= int'(px_flat[i*w_x +: w_x]) &&
                xi <  int'(px_flat[i*w_x +: w_x]) + sprite_size &&
                yi >= int'(py_flat[i*w_y +: w_y]) &&
                yi <  int'(py_flat[i*w_y +: w_y]) + sprite_size) begin
                spr_hit = 1'b1;
                spr_rgb = SPRITE_RGB[3'(i)];
            end
        end
    end

    logic [w_red-1:0]   r_q, r_d;
    logic [w_green-1:0] g_q, g_d;
    logic [w_blue-1:0]  b_q, b_d;

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        unique case (mode_e)
            MODE_STRIPES: begin
                if (x < sweep_q) begin
                    r_d = w_red'((xi + yi) >> 3);
                    g_d = w_green'((xi - yi) >> 3);
                    b_d = w_blue'(xi >> 3);
                end
            end
            MODE_SPRITES: begin
                if (spr_hit) begin
                    r_d = w_red'({4{spr_rgb[11:8]}} >> (16 - w_red));
                    g_d = w_green'({4{spr_rgb[7:4]}} >> (16 - w_green));
                    b_d = w_blue'({4{spr_rgb[3:0]}} >> (16 - w_blue));
                end
            end
            MODE_RING: begin
                if (d2 >= R_IN && d2 < R_OUT) begin
                    r_d = '1;
                    g_d = '1;
                    b_d = w_blue'((xi + yi) >> 3);
                end
            end
            MODE_IDLE: begin
                r_d = {w_red{x < sweep_q}};
                b_d = {w_blue{x >= sweep_q}};
                g_d = {w_green{y < w_y'(screen_height / 2)}};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign red   = r_q;
    assign green = g_q;
    assign blue  = b_q;

endmodule

// File: tb/tb_note_sprite_engine.sv
// tb_note_sprite_engine: directed checks of prescaler, note commit,
// sprite motion and pixel rendering on a shrunken 64x72 screen.
module tb_note_sprite_engine;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic       note_vld;
    logic [3:0] note_idx;
    logic [5:0] x;
    logic [6:0] y;
    logic [3:0] red, green, blue;
    logic [1:0] mode;
    logic       tick;
    logic [11:0] rgb;

    int checks = 0;
    int errors = 0;

    assign rgb = {red, green, blue};

    note_sprite_engine #(
        .screen_width (64),
        .screen_height(72),
        .sprite_size  (20),
        .n_sprites    (4),
        .w_tick       (4),
        .stable_ticks (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .note_vld(note_vld),
        .note_idx(note_idx),
        .x       (x),
        .y       (y),
        .red     (red),
        .green   (green),
        .blue    (blue),
        .mode    (mode),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] k);
        rst      = 1'b1;
        key      = k;
        note_vld = 1'b0;
        note_idx = 4'd0;
        x        = '0;
        y        = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (!tick && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (!tick) check("tick_timeout", 32'(tick), 1);
            @(negedge clk);
        end
    endtask

    task automatic chk_spr(input string tag, input int i,
                           input int ex, input int ey);
        logic [23:0] pxv;
        logic [27:0] pyv;
        pxv = dut.px_flat;
        pyv = dut.py_flat;
        check({tag, "_x"}, 32'(pxv[i*6 +: 6]), ex);
        check({tag, "_y"}, 32'(pyv[i*7 +: 7]), ey);
    endtask

    task automatic pix(input string tag, input int xv, input int yv,
                       input int exp);
        x = 6'(xv);
        y = 7'(yv);
        @(negedge clk);
        check(tag, 32'(rgb), exp);
    endtask

    initial begin
        rst      = 1'b1;
        key      = '0;
        note_vld = 1'b0;
        note_idx = '0;
        x        = '0;
        y        = '0;
        repeat (2) @(negedge clk);
        check("rst_rgb", 32'(rgb), 0);
        check("rst_mode", 32'(mode), 3);
        rst = 1'b0;

        for (int k = 0; k <= 32; k++) begin
            if (k == 0 || k == 1 || k == 15 || k == 16 || k == 32)
                check($sformatf("tick_c%0d", k), 32'(tick),
                      (k % 16 == 0) ? 1 : 0);
            if (k == 1) check("idle_px_c1", 32'(rgb), 'h0FF);
            if (k == 2) check("idle_px_c2", 32'(rgb), 'hFF0);
            @(negedge clk);
        end

        do_reset(4'd0);
        note_vld = 1'b1;
        note_idx = 4'd4;
        repeat (20) @(negedge clk);
        note_idx = 4'd13;
        @(negedge clk);
        note_idx = 4'd4;
        repeat (28) @(negedge clk);
        check("n4_pre", 32'(dut.committed), 'hF);
        @(negedge clk);
        check("n4_commit", 32'(dut.committed), 4);
        check("n4_mode", 32'(mode), 1);

        do_reset(4'd0);
        note_vld = 1'b1;
        note_idx = 4'd4;
        repeat (32) @(negedge clk);
        check("prio_tick", 32'(tick), 1);
        note_idx = 4'd7;
        repeat (49) @(negedge clk);
        check("n7_pre", 32'(dut.committed), 'hF);
        @(negedge clk);
        check("n7_commit", 32'(dut.committed), 7);
        check("n7_mode", 32'(mode), 1);

        do_reset(4'b0001);
        chk_spr("rst_s0", 0, 0, 36);
        chk_spr("rst_s2", 2, 32, 36);
        chk_spr("rst_s3", 3, 43, 36);
        run_ticks(21);
        chk_spr("edge_t21", 0, 42, 25);
        run_ticks(1);
        chk_spr("edge_t22", 0, 43, 23);
        run_ticks(1);
        chk_spr("edge_t23", 0, 41, 21);

        do_reset(4'd0);
        run_ticks(15);
        chk_spr("corner_t15", 1, 1, 51);
        key = 4'b0001;
        run_ticks(1);
        chk_spr("corner_hit", 1, 0, 51);
        key = 4'd0;
        run_ticks(1);
        chk_spr("corner_after", 1, 1, 50);

        do_reset(4'd0);
        run_ticks(3);
        chk_spr("frz_pre_s0", 0, 3, 39);
        chk_spr("frz_pre_s1", 1, 13, 39);
        key = 4'b0010;
        run_ticks(10);
        chk_spr("frz_hold_s0", 0, 3, 39);
        chk_spr("frz_hold_s1", 1, 13, 39);
        key = 4'd0;
        run_ticks(1);
        chk_spr("frz_rel_s0", 0, 4, 40);
        chk_spr("frz_rel_s1", 1, 12, 40);

        do_reset(4'b0010);
        note_vld = 1'b1;
        note_idx = 4'd4;
        run_ticks(5);
        check("spr_mode", 32'(mode), 1);
        pix("spr_overlap", 17, 40, 'hF00);
        pix("spr_s1", 25, 40, 'h0F0);
        pix("spr_above", 17, 30, 'h000);
        pix("spr_s2", 40, 40, 'h00F);
        pix("spr_s3", 60, 40, 'hFF0);
        pix("spr_clamp", 63, 40, 'h000);
        pix("spr_pre_rst", 17, 40, 'hF00);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rgb", 32'(rgb), 0);
        check("async_rst_mode", 32'(mode), 3);

        do_reset(4'b0010);
        note_vld = 1'b1;
        note_idx = 4'd2;
        run_ticks(5);
        check("ring_mode", 32'(mode), 2);
        pix("ring_centre", 10, 46, 'h000);
        pix("ring_inner_r", 20, 46, 'hFF8);
        pix("ring_inner_l", 0, 46, 'hFF5);
        pix("ring_outer", 30, 46, 'h000);
        pix("ring_last", 29, 46, 'hFF9);
        pix("ring_top", 10, 36, 'hFF5);

        do_reset(4'd0);
        note_vld = 1'b1;
        note_idx = 4'd3;
        run_ticks(45);
        check("str_mode", 32'(mode), 0);
        pix("str_in", 40, 16, 'h735);
        pix("str_edge", 44, 16, 'h735);
        pix("str_out", 45, 16, 'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
